mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter and transaction sequencer for the NPC core. It shares one single-outstanding memory port between the instruction-fetch path and the load/store path. Each transaction is accepted, issued downstream, awaited with a timeout, and returned to its owner. The block sits between the core's fetch/LSU logic and the memory model, and replaces direct combinational memory access.

## Interface
- AW, 32, address width
- DW, 32, data width (DW/8 byte-mask bits)
- TIMEOUT, 255, max cycles in WAIT before an error response is generated (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 at a clk edge resets the block)
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  AW  fetch address
- ifu_resp_valid  out  1  fetch response available
- ifu_resp_ready  in  1  fetch response consumed
- ifu_rdata  out  DW  fetched word
- ifu_resp_err  out  1  fetch failed (memory error or timeout)
- lsu_req_valid / lsu_req_ready  in / out  1  load/store request handshake
- lsu_addr  in  AW;  lsu_wen  in  1;  lsu_wdata  in  DW;  lsu_wmask  in  DW/8
- lsu_resp_valid / lsu_resp_ready  out / in  1;  lsu_rdata  out  DW;  lsu_resp_err  out  1
- mem_req_valid  out  1;  mem_req_ready  in  1
- mem_addr  out  AW;  mem_wen  out  1;  mem_wdata  out  DW;  mem_wmask  out  DW/8
- mem_resp_valid  in  1;  mem_rdata  in  DW;  mem_resp_err  in  1 (no backpressure; the arbiter always sinks a response in WAIT)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. One transaction is in flight at a time.
- IDLE:
  - If exactly one requester is valid, it is selected.
  - If both are valid, round-robin selects the requester not granted last. The last-grant register resets to LSU, so the first tie goes to IFU.
  - The selected requester's req_ready=1 combinationally in the same cycle. The other requester's req_ready=0.
  - On the handshake, latch addr/wen/wdata/wmask and the owner id, update last-grant, and go to ISSUE.
  - IFU transactions latch wen=0 and wmask=0.
- ISSUE:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready=1.
  - On the handshake, clear the timer and go to WAIT.
- WAIT:
  - When mem_resp_valid=1, latch rdata and err, go to RESP.
  - Otherwise the timer increments. When timer==TIMEOUT-1 with no response, latch rdata=0, err=1, and go to RESP.
- RESP:
  - The owner's resp_valid=1, with rdata/err stable until the owner's resp_ready=1. Then go to IDLE.
  - The non-owner's resp_valid=0 at all times.
- mem_resp_valid outside WAIT is ignored.
- Memory must not respond to a timed-out transaction. A late response landing in a later WAIT is a system error and is not detected.
- No req_ready is asserted outside IDLE. Requesters keep their valid and fields stable until accepted.

## Timing
- Reset (rst==0 at an edge): state=IDLE, last-grant=LSU, timer=0, latched fields=0. All valid/ready outputs are 0 while rst==0. All data outputs read 0 after reset.
- Reset mid-transaction aborts it. mem_req_valid and resp_valid are 0 from the cycle following the reset edge. No response is delivered for the aborted transaction.
- Minimum latency, with mem_req_ready=1 and a response one cycle after the issue handshake:
  - Accept at cycle 0.
  - mem_req_valid at cycle 1.
  - mem_resp_valid at cycle 2.
  - resp_valid at cycle 3.
- Response handshake at cycle N allows a new accept at cycle N+1. Peak throughput is 1 transaction per 4 cycles.
- Timeout: err response appears TIMEOUT+1 cycles after the ISSUE handshake.
- Timer width is ceil(log2(TIMEOUT+1)). It does not wrap, because WAIT exits at TIMEOUT-1.
- Every output is a function of registered state only, except req_ready. In IDLE, req_ready depends combinationally on the req_valid inputs and last-grant.

## Test plan
- IFU-only read, addr 0x8000_0000, mem returns 0x0000_0413 one cycle after issue -> ifu_resp_valid at cycle 3 with rdata 0x0000_0413, err=0. The LSU side stays idle.
- LSU store, addr 0x8000_0100, wdata 0xDEADBEEF, wmask 4'b0011, mem_req_ready held low 3 cycles -> mem_req_valid is held with stable fields for 4 cycles, then lsu_resp_valid with err=0.
- Both requesters valid continuously after reset -> grant order IFU, LSU, IFU, LSU. Each response goes only to its owner.
- Memory never responds, TIMEOUT=8 -> owner resp_valid at 9 cycles after the issue handshake, rdata=0, err=1, then back to IDLE.
- resp_ready held low 5 cycles in RESP with a new request pending -> resp_valid and rdata are stable and no req_ready is asserted. Acceptance occurs the cycle after resp_ready.
- rst driven low during WAIT, then mem_resp_valid pulses -> no resp_valid to either requester, state is IDLE, and the next tie is granted to IFU.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter that sequences one outstanding
// memory transaction at a time: accept, issue, wait with timeout, respond.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    input  logic            ifu_resp_ready,
    output logic [DW-1:0]   ifu_rdata,
    output logic            ifu_resp_err,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    input  logic            lsu_resp_ready,
    output logic [DW-1:0]   lsu_rdata,
    output logic            lsu_resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_resp_err
);

    localparam int MW = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic            last_grant_r;
    logic            owner_r;
    logic [TW-1:0]   timer_r;
    logic [AW-1:0]   addr_r;
    logic            wen_r;
    logic [DW-1:0]   wdata_r;
    logic [MW-1:0]   wmask_r;
    logic [DW-1:0]   rdata_r;
    logic            err_r;

    logic            grant_ifu_s;
    logic            grant_lsu_s;
    logic            accept_s;
    logic            issue_done_s;
    logic            capture_s;
    logic            timeout_s;
    logic            timer_inc_s;

    // Round-robin tie-break: on contention the requester not granted last wins.
    assign grant_ifu_s = ifu_req_valid && (!lsu_req_valid || (last_grant_r == OWN_LSU));
    assign grant_lsu_s = lsu_req_valid && !grant_ifu_s;

    // Next-state and transaction-event decode.
    always_comb begin
        state_nx_s   = state_r;
        accept_s     = 1'b0;
        issue_done_s = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        timer_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_ifu_s || grant_lsu_s) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    issue_done_s = 1'b1;
                    state_nx_s   = ST_WAIT;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_RESP;
                end else if (timer_r == TIMER_LAST) begin
                    capture_s  = 1'b1;
                    timeout_s  = 1'b1;
                    state_nx_s = ST_RESP;
                end else begin
                    timer_inc_s = 1'b1;
                end
            end
            ST_RESP: begin
                if ((owner_r == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register, grant history and wait timer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= OWN_LSU;
            timer_r      <= '0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                last_grant_r <= grant_ifu_s ? OWN_IFU : OWN_LSU;
            end
            if (issue_done_s) begin
                timer_r <= '0;
            end else if (timer_inc_s) begin
                timer_r <= timer_r + TW'(1);
            end
        end
    end

    // Transaction fields latched at accept; response captured on leaving WAIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_r <= OWN_IFU;
            addr_r  <= '0;
            wen_r   <= 1'b0;
            wdata_r <= '0;
            wmask_r <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                owner_r <= grant_ifu_s ? OWN_IFU : OWN_LSU;
                addr_r  <= grant_ifu_s ? ifu_addr : lsu_addr;
                wen_r   <= grant_ifu_s ? 1'b0 : lsu_wen;
                wdata_r <= grant_ifu_s ? '0 : lsu_wdata;
                wmask_r <= grant_ifu_s ? '0 : lsu_wmask;
            end
            if (capture_s) begin
                rdata_r <= timeout_s ? '0 : mem_rdata;
                err_r   <= timeout_s ? 1'b1 : mem_resp_err;
            end
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign ifu_req_ready  = rst && (state_r == ST_IDLE) && grant_ifu_s;
    assign lsu_req_ready  = rst && (state_r == ST_IDLE) && grant_lsu_s;
    assign mem_req_valid  = rst && (state_r == ST_ISSUE);
    assign ifu_resp_valid = rst && (state_r == ST_RESP) && (owner_r == OWN_IFU);
    assign lsu_resp_valid = rst && (state_r == ST_RESP) && (owner_r == OWN_LSU);

    assign mem_addr     = addr_r;
    assign mem_wen      = wen_r;
    assign mem_wdata    = wdata_r;
    assign mem_wmask    = wmask_r;
    assign ifu_rdata    = rdata_r;
    assign lsu_rdata    = rdata_r;
    assign ifu_resp_err = err_r;
    assign lsu_resp_err = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single reads/writes, round-robin,
// timeout, response backpressure and reset during a transaction.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0; ifu_resp_ready = 1'b0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0; mem_resp_err = 1'b0;

        // Reset state: ready gated while rst low, everything else zero.
        tick(); tick();
        ifu_req_valid = 1'b1;
        settle();
        chk("rst_ifu_ready", {31'h0, ifu_req_ready}, 32'h0);
        chk("rst_mem_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rst_ifu_rdata", ifu_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        ifu_req_valid = 1'b0;
        tick();
        rst = 1'b1;

        // IFU-only read, minimum latency.
        tick();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        settle();
        chk("t1_ifu_ready", {31'h0, ifu_req_ready}, 32'h1);
        chk("t1_lsu_ready", {31'h0, lsu_req_ready}, 32'h0);
        tick();
        ifu_req_valid = 1'b0; ifu_addr = 32'h0; mem_req_ready = 1'b1;
        settle();
        chk("t1_mem_valid", {31'h0, mem_req_valid}, 32'h1);
        chk("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk("t1_mem_wen", {31'h0, mem_wen}, 32'h0);
        chk("t1_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        settle();
        chk("t1_wait_mem_valid", {31'h0, mem_req_valid}, 32'h0);
        tick();
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        settle();
        chk("t1_resp_valid", {31'h0, ifu_resp_valid}, 32'h1);
        chk("t1_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_err", {31'h0, ifu_resp_err}, 32'h0);
        chk("t1_lsu_resp_valid", {31'h0, lsu_resp_valid}, 32'h0);
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        settle();
        chk("t1_resp_done", {31'h0, ifu_resp_valid}, 32'h0);

        // LSU store with mem_req_ready low for 3 cycles.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        settle();
        chk("t2_lsu_ready", {31'h0, lsu_req_ready}, 32'h1);
        tick();
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            settle();
            chk("t2_mem_valid", {31'h0, mem_req_valid}, 32'h1);
            chk("t2_mem_addr", mem_addr, 32'h8000_0100);
            chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("t2_mem_wmask", {28'h0, mem_wmask}, 32'h3);
            chk("t2_mem_wen", {31'h0, mem_wen}, 32'h1);
            tick();
        end
        mem_req_ready = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        settle();
        chk("t2_resp_valid", {31'h0, lsu_resp_valid}, 32'h1);
        chk("t2_err", {31'h0, lsu_resp_err}, 32'h0);
        chk("t2_ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);
        lsu_resp_ready = 1'b1;
        tick();
        lsu_resp_ready = 1'b0;

        // Both requesters valid continuously: IFU, LSU, IFU, LSU.
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t3_ifu_ready", {31'h0, ifu_req_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("t3_lsu_ready", {31'h0, lsu_req_ready}, (k % 2 == 1) ? 32'h1 : 32'h0);
            tick();
            mem_req_ready = 1'b1;
            settle();
            chk("t3_mem_addr", mem_addr, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            chk("t3_issue_no_ready", {31'h0, ifu_req_ready | lsu_req_ready}, 32'h0);
            tick();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h100 + k;
            tick();
            mem_resp_valid = 1'b0;
            settle();
            chk("t3_ifu_resp", {31'h0, ifu_resp_valid}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("t3_lsu_resp", {31'h0, lsu_resp_valid}, (k % 2 == 1) ? 32'h1 : 32'h0);
            chk("t3_rdata", (k % 2 == 0) ? ifu_rdata : lsu_rdata, 32'h100 + k);
            ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
            tick();
            ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // Timeout: no memory response, error 9 cycles after issue handshake.
        tick();
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_3000;
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_req_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            settle();
            chk("t4_no_resp_yet", {31'h0, ifu_resp_valid}, 32'h0);
            tick();
        end
        settle();
        chk("t4_resp_valid", {31'h0, ifu_resp_valid}, 32'h1);
        chk("t4_rdata", ifu_rdata, 32'h0);
        chk("t4_err", {31'h0, ifu_resp_err}, 32'h1);
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        settle();
        chk("t4_back_idle", {31'h0, ifu_resp_valid}, 32'h0);

        // Response backpressure with a pending IFU request.
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_4000; lsu_wen = 1'b0;
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_5000;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("t5_resp_held", {31'h0, lsu_resp_valid}, 32'h1);
            chk("t5_rdata_held", lsu_rdata, 32'hCAFE_F00D);
            chk("t5_no_req_ready", {31'h0, ifu_req_ready | lsu_req_ready}, 32'h0);
            tick();
        end
        lsu_resp_ready = 1'b1;
        settle();
        chk("t5_ready_cycle_no_accept", {31'h0, ifu_req_ready}, 32'h0);
        tick();
        lsu_resp_ready = 1'b0;
        settle();
        chk("t5_accept_next", {31'h0, ifu_req_ready}, 32'h1);
        chk("t5_resp_gone", {31'h0, lsu_resp_valid}, 32'h0);
        tick();

        // Reset during WAIT aborts the transaction; last grant returns to LSU.
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        chk("t6_rst_mem_valid", {31'h0, mem_req_valid}, 32'h0);
        tick();
        rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h5555_5555;
        settle();
        chk("t6_mem_addr_cleared", mem_addr, 32'h0);
        tick();
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t6_no_ifu_resp", {31'h0, ifu_resp_valid}, 32'h0);
            chk("t6_no_lsu_resp", {31'h0, lsu_resp_valid}, 32'h0);
            tick();
        end
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        settle();
        chk("t6_tie_ifu", {31'h0, ifu_req_ready}, 32'h1);
        chk("t6_tie_lsu", {31'h0, lsu_req_ready}, 32'h0);
        chk("t6_rdata_cleared", ifu_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
